md_issue_ctrl: RTL

Issue and writeback controller for the iterative multiply/divide unit attached to the EX stage of the 5-stage RV32 pipeline. It accepts one mul/div operation at a time from ID and starts the shared unit. It tracks the operation's busy destination register, stalling ID on RAW, WAW and structural hazards. It then holds the result until the shared integer writeback port is free of MEM-stage traffic.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_hazard_cmp.sv | 35 +++
 rtl/md_issue_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the mul/div issue controller and its future
// FP-divide sibling: FSM state encoding, default latencies, counter width and
// the helper that computes the RUN counter preload for an operation class.
// -----------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int CNT_W          = 6;

  // RUN lasts exactly n cycles: the counter is preloaded with n-1 and DONE
  // follows the cycle in which it reads zero.
  function automatic logic [CNT_W-1:0] run_cnt_init(input logic is_div,
                                                    input int   mul_cycles,
                                                    input int   div_cycles);
    int n;
    n = is_div ? div_cycles : mul_cycles;
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/md_hazard_cmp.sv
// -----------------------------------------------------------------------------
// md_hazard_cmp
// Purely combinational comparison of an ID-stage instruction against the
// destination register of an in-flight long-latency operation.
//   busy_rd          in  5  destination held by the in-flight operation (0 = none)
//   rs1 / rs2        in  5  ID source registers
//   rs1_used/rs2_used in 1  source is actually read
//   rd               in  5  ID destination
//   regwrite         in  1  ID instruction writes rd
//   raw              out 1  ID reads the busy register
//   waw              out 1  ID writes the busy register
// x0 is never busy, so a zero busy_rd disables both outputs.
// -----------------------------------------------------------------------------
module md_hazard_cmp (
  input  logic [4:0] busy_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       regwrite,
  output logic       raw,
  output logic       waw
);

  logic busy_nz;

  assign busy_nz = (busy_rd != 5'd0);

  assign raw = busy_nz & ((rs1_used & (rs1 == busy_rd)) |
                          (rs2_used & (rs2 == busy_rd)));

  assign waw = busy_nz & regwrite & (rd == busy_rd);

endmodule

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
// Issue/writeback controller for the iterative mul/div unit in EX. Accepts one
// operation at a time from ID, pulses the unit start, times the RUN phase with
// a down-counter, then holds the result until the shared writeback port is not
// claimed by MEM. Stalls ID on structural, RAW and WAW hazards against the
// in-flight destination, through the writeback cycle itself.
//   clk, rst_n                       clock / async active-low reset
//   id_md_req, id_is_div             ID mul/div request and its class
//   id_rd, id_regwrite               ID destination and write enable
//   id_rs1/2, id_rs1/2_used          ID sources and their use flags
//   flush                            kills the ID instruction this cycle
//   mem_regwrite                     MEM owns the writeback port this cycle
//   unit_start, unit_is_div          start pulse and class to the unit
//   md_stall                         freeze PC/IF/ID, bubble into EX
//   wb_valid, wb_fire, wb_rd         held result, write strobe, destination
// -----------------------------------------------------------------------------
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_md_req,
  input  logic       id_is_div,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       flush,
  input  logic       mem_regwrite,
  output logic       unit_start,
  output logic       unit_is_div,
  output logic       md_stall,
  output logic       wb_valid,
  output logic       wb_fire,
  output logic [4:0] wb_rd
);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       busy_rd;
  logic             is_div;

  logic issue;
  logic busy;
  logic raw, waw;

  // A flushed ID instruction is younger than the branch and must not start.
  // An operation already past IDLE is older and is never cancelled here.
  assign issue = (state == IDLE) & id_md_req & ~flush;
  assign busy  = (state != IDLE);

  md_hazard_cmp u_hazard_cmp (
    .busy_rd  (busy_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (id_rd),
    .regwrite (id_regwrite),
    .raw      (raw),
    .waw      (waw)
  );

  // Held through the wb_fire cycle (state is still DONE), released the cycle
  // after, when the regfile already holds the value. flush is deliberately
  // not a term: the hazard unit ORs the two stall sources.
  assign md_stall = busy & (id_md_req | raw | waw);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      busy_rd <= 5'd0;
      is_div  <= 1'b0;
    end else if (issue) begin
      cnt     <= run_cnt_init(id_is_div, MUL_CYCLES, DIV_CYCLES);
      // A non-writing op gets busy_rd=0: no hazards, result discarded.
      busy_rd <= id_regwrite ? id_rd : 5'd0;
      is_div  <= id_is_div;
    end else if ((state == RUN) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    unit_start  = 1'b0;
    unit_is_div = is_div;
    wb_valid    = 1'b0;
    wb_fire     = 1'b0;
    wb_rd       = 5'd0;

    case (state)
      IDLE: begin
        if (issue) begin
          unit_start  = 1'b1;
          unit_is_div = id_is_div;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end

      DONE: begin
        wb_rd = busy_rd;
        if (busy_rd == 5'd0) begin
          // Discarded result: one DONE cycle, no writeback request.
          state_next = IDLE;
        end else begin
          wb_valid = 1'b1;
          // MEM always wins the shared port; wait it out in DONE.
          if (!mem_regwrite) begin
            wb_fire    = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
